// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: controller state encoding, bus-level constants and
// small helpers used by the register-interface slave.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    PTR,
    ACK_PTR,
    WRDATA,
    ACK_WR,
    RDDATA,
    RDACK
  } state_t;

  localparam logic        ACK       = 1'b0;
  localparam logic        NACK      = 1'b1;
  localparam logic        RW_READ   = 1'b1;
  localparam int unsigned RW_BIT    = 0;
  localparam logic [3:0]  BYTE_BITS = 4'd8;

  // Open-drain: a 0 on the wire means pulling SDA low.
  function automatic logic oe_for(input logic bit_val);
    return ~bit_val;
  endfunction

  function automatic int unsigned ptr_bytes(input int unsigned addr_w);
    return (addr_w > 8) ? 2 : 1;
  endfunction

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Bus-side (SCL/SDA) and register-side (pointer, data, strobes) signals of the
// I2C register-interface slave.
interface i2c_slave_regif_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              scl;
  logic              sda_in;
  logic              sda_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  scl, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport master (
    output scl, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions,
// all derived from the synchronised copies only.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C slave exposing a byte-wide register space: write pointer then data, or read
// sequentially from the pointer; pointer auto-increments and wraps.
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned ADDR_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  i2c_slave_regif_if.slave bus
);

  localparam int unsigned       PTR_BYTES = ptr_bytes(ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [3:0]        BIT_ONE   = 4'd1;

  logic sync_sda, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (bus.scl),
    .sda      (bus.sda_in),
    .sda_s    (sync_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        ptr_hi_q, ptr_hi_d;
  logic              ptr_idx_q, ptr_idx_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              rd_load_q;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;

  logic        byte_full;
  logic        last_ptr;
  logic [15:0] ptr_word;

  assign byte_full = (bit_cnt_q == BYTE_BITS);
  assign last_ptr  = (PTR_BYTES == 1) || ptr_idx_q;
  // Pointer bits are taken MSB-first from the received byte(s).
  assign ptr_word  = (PTR_BYTES == 2) ? {ptr_hi_q, shreg_q} : {shreg_q, 8'h00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_hi_q  <= '0;
      ptr_idx_q <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_load_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_hi_q  <= ptr_hi_d;
      ptr_idx_q <= ptr_idx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_load_q <= re_q;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = rd_load_q ? bus.mem_rdata : shreg_q;
    ptr_hi_d  = ptr_hi_q;
    ptr_idx_d = ptr_idx_q;
    rw_d      = rw_q;
    addr_d    = we_q ? addr_q + ADDR_ONE : addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: sda_oe_d = 1'b0;

      DEVADDR, PTR, WRDATA: begin
        sda_oe_d = 1'b0;
        if (scl_rise && !byte_full) begin
          shreg_d   = {shreg_q[6:0], sync_sda};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end else if (scl_fall && byte_full) begin
          bit_cnt_d = '0;
          sda_oe_d  = oe_for(ACK);
          case (state_q)
            DEVADDR: begin
              if (shreg_q[7:1] == DEV_ADDR) begin
                state_d = ACK_DEV;
                rw_d    = shreg_q[RW_BIT];
                busy_d  = 1'b1;
              end else begin
                state_d  = IDLE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end
            PTR: begin
              state_d = ACK_PTR;
              if (last_ptr) addr_d   = ptr_word[15 -: ADDR_W];
              else          ptr_hi_d = shreg_q;
            end
            default: begin
              state_d = ACK_WR;
              wdata_d = shreg_q;
              we_d    = 1'b1;
            end
          endcase
        end
      end

      // A read starts on the ACK-bit rising edge so the fetched byte is in the
      // shift register before SCL falls and bit 7 must be driven.
      ACK_DEV: begin
        if (rw_q == RW_READ) begin
          if (scl_rise) begin
            state_d = RDDATA;
            re_d    = 1'b1;
          end
        end else if (scl_fall) begin
          state_d   = PTR;
          sda_oe_d  = 1'b0;
          ptr_idx_d = 1'b0;
        end
      end

      ACK_PTR: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          state_d   = last_ptr ? WRDATA : PTR;
          ptr_idx_d = ~last_ptr;
        end
      end

      ACK_WR: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = WRDATA;
        end
      end

      RDDATA: begin
        if (scl_fall) begin
          if (!byte_full) begin
            sda_oe_d  = oe_for(shreg_q[7]);
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = RDACK;
          end
        end
      end

      // After a master NACK the slave stays passive (IDLE) but busy until STOP.
      RDACK: begin
        if (scl_rise) begin
          bit_cnt_d = '0;
          if (sync_sda == NACK) begin
            state_d = IDLE;
          end else begin
            state_d = RDDATA;
            addr_d  = addr_q + ADDR_ONE;
            re_d    = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (bus_start) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
    end else if (bus_stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: a table of write transactions plus hand-written
// combined-read, aborted-write and reset-during-read sequences.
module tb_i2c_slave_regif;

  localparam int Q = 50;  // quarter SCL period; clk period is 10

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;

  i2c_slave_regif_if #(.ADDR_W(8)) bus ();

  i2c_slave_regif #(.DEV_ADDR(7'h48), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl    = scl_drv;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  // Register-file responder and transaction logs.
  logic [7:0] tb_mem [256];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] rd_addr_q [$];
  int         busy_cycles = 0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) begin
      rd_addr_q.push_back(bus.mem_addr);
      bus.mem_rdata <= tb_mem[bus.mem_addr];
    end else begin
      bus.mem_rdata <= 8'hEE;
    end
    if (bus.busy) busy_cycles <= busy_cycles + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    if (!scl_drv) begin
      sda_drv = 1'b1; #Q;
      scl_drv = 1'b1; #Q;
    end
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    b = bus.sda_in; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  typedef struct {
    string      name;
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;   // 0 = device address acknowledged
    logic [7:0] exp_a0;
    logic [7:0] exp_a1;
    logic [7:0] exp_end;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic       a;
    logic       b;
    logic [7:0] d;
    int         w0, r0, b0;

    vecs[0] = '{"wr_basic",   8'h90, 8'h10, 8'hA5, 8'h3C, 1'b0, 8'h10, 8'h11, 8'h12};
    vecs[1] = '{"wr_wrap",    8'h90, 8'hFF, 8'h11, 8'h22, 1'b0, 8'hFF, 8'h00, 8'h01};
    vecs[2] = '{"wr_badaddr", 8'h92, 8'h10, 8'h55, 8'h66, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{"wr_mid",     8'h90, 8'h40, 8'h00, 8'hFF, 1'b0, 8'h40, 8'h41, 8'h42};

    #100;
    check("rst_sda_oe",    bus.sda_oe,    0);
    check("rst_busy",      bus.busy,      0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_re",    bus.mem_re,    0);
    rst_n = 1'b1;
    #100;

    for (int i = 0; i < 4; i++) begin
      w0 = wr_addr_q.size();
      r0 = rd_addr_q.size();
      b0 = busy_cycles;
      bus_start();
      send_byte(vecs[i].dev, a);
      check({vecs[i].name, "_devack"}, a, vecs[i].exp_ack);
      if (vecs[i].exp_ack == 1'b0) begin
        send_byte(vecs[i].ptr, a); check({vecs[i].name, "_ptrack"}, a, 0);
        send_byte(vecs[i].d0, a);  check({vecs[i].name, "_d0ack"},  a, 0);
        send_byte(vecs[i].d1, a);  check({vecs[i].name, "_d1ack"},  a, 0);
      end
      bus_stop();
      check({vecs[i].name, "_busy_end"},  bus.busy,   0);
      check({vecs[i].name, "_oe_end"},    bus.sda_oe, 0);
      check({vecs[i].name, "_reads"},     rd_addr_q.size() - r0, 0);
      if (vecs[i].exp_ack == 1'b0) begin
        check({vecs[i].name, "_writes"},   wr_addr_q.size() - w0, 2);
        check({vecs[i].name, "_busy_seen"}, (busy_cycles > b0), 1);
        check({vecs[i].name, "_end_addr"}, bus.mem_addr, vecs[i].exp_end);
        if (wr_addr_q.size() >= w0 + 2) begin
          check({vecs[i].name, "_a0"}, wr_addr_q[w0],     vecs[i].exp_a0);
          check({vecs[i].name, "_w0"}, wr_data_q[w0],     vecs[i].d0);
          check({vecs[i].name, "_a1"}, wr_addr_q[w0 + 1], vecs[i].exp_a1);
          check({vecs[i].name, "_w1"}, wr_data_q[w0 + 1], vecs[i].d1);
        end
      end else begin
        check({vecs[i].name, "_writes"},    wr_addr_q.size() - w0, 0);
        check({vecs[i].name, "_busy_cyc"},  busy_cycles - b0, 0);
      end
    end

    // Combined transaction: set pointer, repeated START, read two bytes.
    w0 = wr_addr_q.size();
    r0 = rd_addr_q.size();
    bus_start();
    send_byte(8'h90, a); check("rd_devw_ack", a, 0);
    send_byte(8'h10, a); check("rd_ptr_ack",  a, 0);
    bus_start();
    send_byte(8'h91, a); check("rd_devr_ack", a, 0);
    recv_byte(d, 1'b0);  check("rd_byte0", d, 8'hA5);
    recv_byte(d, 1'b1);  check("rd_byte1", d, 8'h3C);
    bus_stop();
    check("rd_re_count", rd_addr_q.size() - r0, 2);
    if (rd_addr_q.size() >= r0 + 2) begin
      check("rd_addr0", rd_addr_q[r0],     8'h10);
      check("rd_addr1", rd_addr_q[r0 + 1], 8'h11);
    end
    check("rd_writes",   wr_addr_q.size() - w0, 0);
    check("rd_end_addr", bus.mem_addr, 8'h11);
    check("rd_busy_end", bus.busy, 0);

    // STOP in the middle of a data byte discards it.
    w0 = wr_addr_q.size();
    bus_start();
    send_byte(8'h90, a); check("abort_dev_ack", a, 0);
    send_byte(8'h20, a); check("abort_ptr_ack", a, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop();
    check("abort_writes", wr_addr_q.size() - w0, 0);
    check("abort_oe",     bus.sda_oe, 0);
    check("abort_busy",   bus.busy,   0);
    check("abort_addr",   bus.mem_addr, 8'h20);

    // Preload zeros, then reset while the slave drives read bit 3.
    bus_start();
    send_byte(8'h90, a); check("pre_dev_ack", a, 0);
    send_byte(8'h30, a);
    send_byte(8'h00, a);
    send_byte(8'h00, a);
    bus_stop();
    bus_start();
    send_byte(8'h90, a);
    send_byte(8'h30, a);
    bus_start();
    send_byte(8'h91, a); check("rst_rd_ack", a, 0);
    for (int i = 7; i >= 4; i--) begin
      recv_bit(b);
      check($sformatf("rst_rd_bit%0d", i), b, 0);
    end
    check("rst_drive_bit3", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", bus.sda_oe, 0);
    check("rst_async_busy", bus.busy, 0);
    #19;
    rst_n = 1'b1;
    #Q;
    bus_stop();
    check("rst_addr_clr", bus.mem_addr, 0);

    w0 = wr_addr_q.size();
    bus_start();
    send_byte(8'h90, a); check("post_dev_ack", a, 0);
    send_byte(8'h50, a); check("post_ptr_ack", a, 0);
    send_byte(8'h77, a); check("post_d0_ack",  a, 0);
    send_byte(8'h78, a); check("post_d1_ack",  a, 0);
    bus_stop();
    check("post_writes", wr_addr_q.size() - w0, 2);
    if (wr_addr_q.size() >= w0 + 2) begin
      check("post_a0", wr_addr_q[w0],     8'h50);
      check("post_w0", wr_data_q[w0],     8'h77);
      check("post_a1", wr_addr_q[w0 + 1], 8'h51);
      check("post_w1", wr_data_q[w0 + 1], 8'h78);
    end
    check("post_end_addr", bus.mem_addr, 8'h52);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regif.md
I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 Parameter DEV_ADDR, default 7'h48, 7-bit I2C device address this slave answers to.
REQ-002 Parameter ADDR_W, default 8, register-pointer width; memory depth 2**ADDR_W bytes.
REQ-003 Clk  input  1  system clock, at least 8x SCL rate.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Scl  input  1  I2C clock from bus; asynchronous to Clk.
REQ-006 Sda_in  input  1  I2C data from bus; asynchronous to Clk.
REQ-007 Sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 MemAddr  output  ADDR_W  current register pointer.
REQ-009 MemWdata  output  8  byte received from master.
REQ-010 MemWe  output  1  one-Clk write strobe for MemWdata at MemAddr.
REQ-011 MemRe  output  1  one-Clk read request at MemAddr.
REQ-012 MemRdata  input  8  read byte, valid exactly 1 Clk after MemRe.
REQ-013 Busy  output  1  high from an addressed START until STOP or NACKed address.

Function
REQ-014 Scl and Sda_in SHALL each pass a 2-flop synchroniser; edges SHALL be detected on synchronised values only.
REQ-015 START = synced SDA falls while synced SCL high; STOP = synced SDA rises while synced SCL high; both valid in any state, START in any state = repeated start.
REQ-016 Bits SHALL be sampled on the synced SCL rising edge, MSB first; Sda_oe SHALL change only one Clk after a synced SCL falling edge.
REQ-017 FSM states: IDLE, DEVADDR, ACK_DEV, PTR, ACK_PTR, WRDATA, ACK_WR, RDDATA, RDACK.
REQ-018 IDLE -> DEVADDR on START; 8 bits collected (7 address + R/W).
REQ-019 Address match -> ACK_DEV (drive ACK 0); mismatch -> IDLE, no ACK, Busy low.
REQ-020 After ACK_DEV: R/W=0 -> PTR; R/W=1 -> RDDATA.
REQ-021 PTR receives ADDR_W bits (first ADDR_W bits of one byte if ADDR_W<=8, two bytes MSB-first if 8<ADDR_W<=16); ACK_PTR ACKs each byte; then WRDATA.
REQ-022 WRDATA: 8 bits -> ACK_WR drives ACK, MemWe pulses once during the ACK bit, MemAddr increments after the pulse.
REQ-023 Read: MemRe pulses once on entry to RDDATA (after ACK_DEV or after master ACK); MemRdata latched into shift register before first SCL falling edge of the byte.
REQ-024 RDACK: master ACK (0) -> MemAddr increments, next byte; master NACK (1) -> release SDA, wait for STOP/START in IDLE-equivalent passive state.
REQ-025 MemAddr SHALL wrap from 2**ADDR_W-1 to 0.
REQ-026 Repeated START after PTR/write SHALL keep MemAddr (combined write-pointer/read transaction).
REQ-027 STOP in any state -> IDLE, Sda_oe=0, Busy=0, in the Clk after detection; partial byte discarded, no MemWe.
REQ-028 Sda_oe SHALL never assert during a START/STOP condition or in IDLE/DEVADDR.
REQ-029 Bit counter SHALL be 4 bits and reset at every START and every byte boundary.

Reset
REQ-030 Rst_n low SHALL force IDLE, Sda_oe=0, MemWe=0, MemRe=0, Busy=0, MemAddr=0, MemWdata=0, synchronisers to 1 (bus idle).
REQ-031 Reset mid-transfer SHALL release SDA immediately (asynchronous) and ignore bus until next START.

Structure
REQ-032 State encoding and I2C constants (ACK=0, NACK=1, R/W bit position) SHALL live in shared package i2c_pkg.
REQ-033 Synchroniser plus START/STOP/edge detection SHALL be sub-module i2c_bus_sync.

Verification
REQ-034 Write: START, 0x90, ptr 0x10, data 0xA5,0x3C, STOP -> ACK on all 4 bytes; MemWe at 0x10=0xA5, 0x11=0x3C.
REQ-035 Combined read: START 0x90, ptr 0x10, repeated START 0x91, master ACK, NACK -> Sda carries 0xA5 then 0x3C MSB-first; MemRe twice.
REQ-036 Wrong address 0x92 -> no ACK, Busy stays low, no MemWe/MemRe.
REQ-037 Pointer 0xFF, write 0x11,0x22 -> writes at 0xFF then 0x00.
REQ-038 STOP after 4 data bits of a write byte -> no MemWe, IDLE, Sda_oe=0.
REQ-039 Rst_n low during read-data bit 3 -> Sda_oe=0 immediately; next START 0x90 transaction completes normally.
